// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: RC4 key scheduling plus keystream generation that decrypts a
// ciphertext ROM into a plaintext RAM, one byte at a time, with an optional
// check that every plaintext byte is a space or a lowercase letter.
// The 256x8 S-box lives in an external synchronous RAM (1-cycle read latency).
module rc4_decrypt_core #(
   parameter  int KEY_BYTES = 3,
   parameter  int MSG_LEN   = 32,
   localparam int KW        = 8 * KEY_BYTES,
   localparam int AW        = $clog2(MSG_LEN)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [KW-1:0] key,
   input  logic          check_en,
   output logic          busy,
   output logic          done,
   output logic          valid,
   output logic [AW-1:0] fail_index,
   output logic [7:0]    s_addr,
   output logic [7:0]    s_wdata,
   output logic          s_wren,
   input  logic [7:0]    s_rdata,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_rdata,
   output logic [AW-1:0] dec_addr,
   output logic [7:0]    dec_wdata,
   output logic          dec_wren
);

   localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [4:0] {
      IDLE, INIT,
      K_RI, K_LI, K_RJ, K_LJ, K_WI, K_WJ,
      P_RI, P_LI, P_RJ, P_LJ, P_WI, P_WJ, P_RF, P_LF, P_WD,
      DONE
   } state_t;

   state_t          state, state_n;
   logic [KW-1:0]   key_q;
   logic            check_q;
   logic [7:0]      i, j, si, sj, f, enc;
   logic [AW-1:0]   k;
   logic [KIW-1:0]  kidx;
   logic [7:0]      key_byte;
   logic [7:0]      plain;
   logic            byte_ok;
   logic            last_byte;

   // Select the current key byte with a mux over the wrapping key index.
   always_comb begin
      key_byte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (kidx == KIW'(b)) key_byte = key_q[KW-1-8*b -: 8];
      end
   end

   assign plain     = f ^ enc;
   assign byte_ok   = !check_q || (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A));
   assign last_byte = (k == AW'(MSG_LEN - 1));
   assign rom_addr  = k;

   // State register.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state decode and the RAM/ROM strobes driven from the current state.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      busy      = 1'b1;
      done      = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_wren    = 1'b0;
      dec_addr  = '0;
      dec_wdata = '0;
      dec_wren  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_n = INIT;
         end
         INIT: begin
            s_addr  = i;
            s_wdata = i;
            s_wren  = 1'b1;
            if (i == 8'hFF) state_n = K_RI;
         end
         K_RI: begin s_addr = i; state_n = K_LI; end
         K_LI: state_n = K_RJ;
         K_RJ: begin s_addr = j; state_n = K_LJ; end
         K_LJ: state_n = K_WI;
         K_WI: begin
            s_addr = i; s_wdata = sj; s_wren = 1'b1;
            state_n = K_WJ;
         end
         K_WJ: begin
            s_addr = j; s_wdata = si; s_wren = 1'b1;
            state_n = (i == 8'hFF) ? P_RI : K_RI;
         end
         P_RI: begin s_addr = i + 8'd1; state_n = P_LI; end
         P_LI: state_n = P_RJ;
         P_RJ: begin s_addr = j; state_n = P_LJ; end
         P_LJ: state_n = P_WI;
         P_WI: begin
            s_addr = i; s_wdata = sj; s_wren = 1'b1;
            state_n = P_WJ;
         end
         P_WJ: begin
            s_addr = j; s_wdata = si; s_wren = 1'b1;
            state_n = P_RF;
         end
         P_RF: begin s_addr = si + sj; state_n = P_LF; end
         P_LF: state_n = P_WD;
         P_WD: begin
            dec_addr  = k;
            dec_wdata = plain;
            dec_wren  = 1'b1;
            if (!byte_ok || last_byte) state_n = DONE;
            else                       state_n = P_RI;
         end
         DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: indices, captured S-box values and the latched result.
   // NOTE: every register here is reset; the S-box storage itself is external
   // and never cleared, because INIT rewrites all 256 entries on each run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q      <= '0;
         check_q    <= 1'b0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         kidx       <= '0;
         si         <= '0;
         sj         <= '0;
         f          <= '0;
         enc        <= '0;
         valid      <= 1'b0;
         fail_index <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               key_q      <= key;
               check_q    <= check_en;
               valid      <= 1'b0;
               fail_index <= '0;
               i          <= '0;
               j          <= '0;
               k          <= '0;
               kidx       <= '0;
            end
            INIT: i <= i + 8'd1;
            K_LI: begin
               si <= s_rdata;
               j  <= j + s_rdata + key_byte;
            end
            K_LJ: sj <= s_rdata;
            K_WJ: begin
               i    <= i + 8'd1;
               kidx <= (kidx == KIW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
               if (i == 8'hFF) begin
                  j <= '0;
                  k <= '0;
               end
            end
            P_RI: i <= i + 8'd1;
            P_LI: begin
               si <= s_rdata;
               j  <= j + s_rdata;
            end
            P_LJ: sj <= s_rdata;
            P_LF: begin
               f   <= s_rdata;
               enc <= rom_rdata;
            end
            P_WD: begin
               if (!byte_ok)      fail_index <= k;
               else if (last_byte) valid     <= 1'b1;
               else               k          <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: external S-box RAM, ciphertext ROM and plaintext
// RAM models, directed vectors plus randomized keys/messages checked against
// a plain-arithmetic RC4 reference model.
module tb_rc4_decrypt_core;

   localparam int KB = 3;
   localparam int ML = 9;
   localparam int AW = $clog2(ML);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [23:0]   key;
   logic          check_en;
   logic          busy, done, valid;
   logic [AW-1:0] fail_index;
   logic [7:0]    s_addr, s_wdata, s_rdata;
   logic          s_wren;
   logic [AW-1:0] rom_addr, dec_addr;
   logic [7:0]    rom_rdata, dec_wdata;
   logic          dec_wren;

   logic [7:0] sbox    [256];
   logic [7:0] rom_mem [16];
   logic [7:0] dec_mem [16];
   int         dec_writes;
   logic       dec_clear = 1'b0;

   logic [7:0] exp_dec [ML];
   logic [7:0] ref_ks  [ML];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rc4_decrypt_core #(.KEY_BYTES(KB), .MSG_LEN(ML)) dut (
      .clk(clk), .reset(reset), .start(start), .key(key), .check_en(check_en),
      .busy(busy), .done(done), .valid(valid), .fail_index(fail_index),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
      .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren)
   );

   always @(posedge clk) begin
      if (s_wren) sbox[s_addr] <= s_wdata;
      s_rdata <= sbox[s_addr];
   end

   always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

   always @(posedge clk) begin
      if (dec_clear) begin
         for (int m = 0; m < 16; m++) dec_mem[m] <= 8'hEE;
         dec_writes <= 0;
      end else if (dec_wren) begin
         dec_mem[dec_addr] <= dec_wdata;
         dec_writes        <= dec_writes + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit printable(input logic [7:0] b);
      return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
   endfunction

   // Textbook RC4: KSA then PRGA, producing ML keystream bytes.
   function automatic void rc4_model(input logic [23:0] kv);
      int s [256];
      int jj, t, x, y, kbv;
      for (int n = 0; n < 256; n++) s[n] = n;
      jj = 0;
      for (int n = 0; n < 256; n++) begin
         kbv = int'((kv >> (8 * (KB - 1 - (n % KB)))) & 24'hFF);
         jj  = (jj + s[n] + kbv) % 256;
         t = s[n]; s[n] = s[jj]; s[jj] = t;
      end
      x = 0; y = 0;
      for (int m = 0; m < ML; m++) begin
         x = (x + 1) % 256;
         y = (y + s[x]) % 256;
         t = s[x]; s[x] = s[y]; s[y] = t;
         ref_ks[m] = 8'(s[(s[x] + s[y]) % 256]);
      end
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_flags"}, {27'd0, busy, done, valid, s_wren, dec_wren}, 32'd0);
      check({tag, "_addrs"}, {s_addr, s_wdata, 4'(rom_addr), 4'(dec_addr), dec_wdata}, 32'd0);
      check({tag, "_fail_index"}, 32'(fail_index), 32'd0);
   endtask

   task automatic clear_dec();
      @(negedge clk) dec_clear = 1'b1;
      @(negedge clk) dec_clear = 1'b0;
   endtask

   // One full run: expected bytes come from exp_dec; outcome from the byte rule.
   task automatic run_op(input logic [23:0] kv, input logic chk, input bit extra, input string tag);
      int   cyc;
      bit   init_ok;
      bit   found;
      int   exp_n;
      logic exp_valid;
      int   exp_fail;
      exp_n = ML; exp_valid = 1'b1; exp_fail = 0; found = 0;
      for (int m = 0; m < ML; m++) begin
         if (!found && chk && !printable(exp_dec[m])) begin
            found = 1; exp_n = m + 1; exp_valid = 1'b0; exp_fail = m;
         end
      end
      clear_dec();
      key = kv; check_en = chk; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key = ~kv; check_en = ~chk;
      cyc = 1; init_ok = 1;
      while (done !== 1'b1 && cyc < 3000) begin
         if (cyc <= 256 && !(s_wren === 1'b1 && s_addr === 8'(cyc - 1) &&
                             s_wdata === 8'(cyc - 1) && busy === 1'b1)) init_ok = 0;
         start = extra && (cyc == 5 || cyc == 300 || cyc == 1800);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_init_sweep"}, 32'(init_ok), 32'd1);
      check({tag, "_done_cycle"}, cyc, 1793 + 9 * exp_n);
      check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
      check({tag, "_fail_index"}, 32'(fail_index), exp_fail);
      check({tag, "_dec_writes"}, dec_writes, exp_n);
      for (int m = 0; m < ML; m++)
         check($sformatf("%s_dec%0d", tag, m), 32'(dec_mem[m]),
               (m < exp_n) ? 32'(exp_dec[m]) : 32'h0000_00EE);
      @(posedge clk); #1;
      check({tag, "_after_done"}, {30'd0, done, busy}, 32'd0);
      check({tag, "_valid_hold"}, 32'(valid), 32'(exp_valid));
   endtask

   initial begin
      logic [7:0]  v3_ct [ML];
      logic [7:0]  v3_pt [ML];
      logic [23:0] kv;
      logic        chk;
      int          bad;
      logic [7:0]  p;
      v3_ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      v3_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      for (int m = 0; m < 16; m++) rom_mem[m] = 8'h00;

      // Reset with undriven inputs.
      reset = 1'b1; start = 1'bx; key = 'x; check_en = 1'bx;
      repeat (3) @(posedge clk);
      #1 check_idle("reset");
      @(negedge clk);
      start = 1'b0; key = '0; check_en = 1'b0; reset = 1'b0;

      // Known-answer vector, unchecked and checked, then with stray starts.
      for (int m = 0; m < ML; m++) begin rom_mem[m] = v3_ct[m]; exp_dec[m] = v3_pt[m]; end
      run_op(24'h4B6579, 1'b0, 1'b0, "v3");
      run_op(24'h4B6579, 1'b1, 1'b0, "v4");
      run_op(24'h4B6579, 1'b0, 1'b1, "v5");

      // Reset in the middle of key scheduling, then a clean rerun.
      @(negedge clk);
      key = 24'h4B6579; check_en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (700) @(posedge clk);
      #3 reset = 1'b1;
      #1 check_idle("v6_midreset");
      @(negedge clk) reset = 1'b0;
      run_op(24'h4B6579, 1'b0, 1'b0, "v6");

      // Randomized keys and messages against the reference model.
      for (int r = 0; r < 4; r++) begin
         kv  = 24'($urandom);
         chk = (r % 2 == 1);
         rc4_model(kv);
         bad = (chk && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, ML - 1)) : -1;
         for (int m = 0; m < ML; m++) begin
            if (chk) p = ($urandom_range(0, 26) == 26) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
            else     p = 8'($urandom);
            if (m == bad) p = 8'h41;
            exp_dec[m] = p;
            rom_mem[m] = p ^ ref_ks[m];
         end
         run_op(kv, chk, 1'b0, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
